// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer for the 32-bit program counter.
// Every cycle it computes the PC register's next value, which the PC register
// loads unconditionally. The next value depends on:
//   - sequential advance (+4)
//   - branch/jump redirects
//   - trap entry
//   - hazard stalls
// It also runs the IMEM request/ready handshake and presents fetched words to decode.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pc                    current PC register value
//   o_pc_next_c             next PC value (combinational)
//   i_stall                 hazard stall, blocks sequential advance only
//   i_redirect_valid/target branch/jump redirect request and destination
//   i_trap                  trap request, highest priority
//   o_imem_req              fetch request
//   o_imem_addr_c           fetch address (always i_pc)
//   i_imem_ready/rdata      IMEM response strobe and instruction word
//   o_instr_valid           o_instr_out/o_fetch_pc valid for decode
//   o_instr_out, o_fetch_pc captured instruction and its address
//   i_id_ready              decode accepts the instruction this cycle
//   o_fault, o_fault_cause  sticky fault flag, cause (01 timeout, 10 misaligned redirect)

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_next_c,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic        i_trap,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr_c,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr_out,
  output logic [31:0] o_fetch_pc,
  input  logic        i_id_ready,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_pend_valid;
  logic              r_pend_trap;
  logic [31:0]       r_pend_target;
  logic              r_imem_req;
  logic              r_instr_valid;
  logic [31:0]       r_instr_out;
  logic [31:0]       r_fetch_pc;
  logic              r_fault;
  logic [1:0]        r_fault_cause;

  state_t            w_state_nxt;
  logic [31:0]       w_pc_next;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic              w_pend_valid_nxt;
  logic              w_pend_trap_nxt;
  logic [31:0]       w_pend_target_nxt;
  logic              w_capture;
  logic [1:0]        w_cause_nxt;
  logic              w_misalign;
  logic              w_redir_ok;
  logic              w_redir_bad;
  logic              w_tgt_valid;
  logic [31:0]       w_tgt;

  assign w_misalign  = (i_redirect_target[1:0] != 2'b00);
  assign w_redir_ok  = i_redirect_valid & ~w_misalign;
  assign w_redir_bad = i_redirect_valid &  w_misalign;

  // Winning control-flow target while a fetch is outstanding in WAIT:
  // a trap (new or pending) beats any redirect, a new redirect replaces an older one.
  always_comb begin
    w_tgt_valid = 1'b0;
    w_tgt       = r_pend_target;
    if (i_trap) begin
      w_tgt_valid = 1'b1;
      w_tgt       = TRAP_VECTOR;
    end else if (r_pend_valid && r_pend_trap) begin
      w_tgt_valid = 1'b1;
      w_tgt       = r_pend_target;
    end else if (w_redir_ok) begin
      w_tgt_valid = 1'b1;
      w_tgt       = i_redirect_target;
    end else if (r_pend_valid) begin
      w_tgt_valid = 1'b1;
      w_tgt       = r_pend_target;
    end
  end

  // Next-state, next-PC and capture decisions.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_next         = i_pc;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_trap_nxt   = r_pend_trap;
    w_pend_target_nxt = r_pend_target;
    w_capture         = 1'b0;
    w_cause_nxt       = r_fault_cause;

    unique case (r_state)
      ST_IDLE: begin
        w_pc_next   = RESET_VECTOR;
        w_state_nxt = ST_REQ;
      end

      ST_REQ: begin
        w_wait_cnt_nxt = '0;
        if (i_trap || w_redir_ok) begin
          // A same-cycle response is dropped and the target applied now.
          // Otherwise the request is already in flight and the target must wait.
          if (i_imem_ready) begin
            w_pc_next   = i_trap ? TRAP_VECTOR : i_redirect_target;
            w_state_nxt = ST_REQ;
          end else begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_trap_nxt   = i_trap;
            w_pend_target_nxt = i_trap ? TRAP_VECTOR : i_redirect_target;
            w_state_nxt       = ST_WAIT;
          end
        end else if (w_redir_bad) begin
          w_cause_nxt = CAUSE_MISALIGN;
          w_state_nxt = ST_FAULT;
        end else if (i_imem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_VALID;
        end else begin
          w_pend_valid_nxt = 1'b0;
          w_pend_trap_nxt  = 1'b0;
          w_state_nxt      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (w_redir_bad && !i_trap && !(r_pend_valid && r_pend_trap)) begin
          w_cause_nxt = CAUSE_MISALIGN;
          w_state_nxt = ST_FAULT;
        end else if (i_imem_ready) begin
          if (w_tgt_valid) begin
            w_pc_next   = w_tgt;
            w_state_nxt = ST_REQ;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_VALID;
          end
        end else if (r_wait_cnt == CNT_LAST) begin
          w_cause_nxt = CAUSE_TIMEOUT;
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_cnt_nxt    = r_wait_cnt + CNT_W'(1);
          w_pend_valid_nxt  = w_tgt_valid;
          w_pend_trap_nxt   = i_trap | (r_pend_valid & r_pend_trap);
          w_pend_target_nxt = w_tgt;
        end
      end

      ST_VALID: begin
        if (i_trap) begin
          w_pc_next   = TRAP_VECTOR;
          w_state_nxt = ST_REQ;
        end else if (w_redir_bad) begin
          w_cause_nxt = CAUSE_MISALIGN;
          w_state_nxt = ST_FAULT;
        end else if (w_redir_ok) begin
          w_pc_next   = i_redirect_target;
          w_state_nxt = ST_REQ;
        end else if (i_id_ready && !i_stall) begin
          w_pc_next   = i_pc + 32'd4;
          w_state_nxt = ST_REQ;
        end
      end

      ST_FAULT: begin
        if (i_trap) begin
          w_pc_next   = TRAP_VECTOR;
          w_cause_nxt = CAUSE_NONE;
          w_state_nxt = ST_REQ;
        end
      end

      default: begin
        w_pc_next   = RESET_VECTOR;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; flags are derived from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_trap   <= 1'b0;
      r_pend_target <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_out   <= '0;
      r_fetch_pc    <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_pend_valid  <= (w_state_nxt == ST_WAIT) & w_pend_valid_nxt;
      r_pend_trap   <= (w_state_nxt == ST_WAIT) & w_pend_trap_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_imem_req    <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT);
      r_instr_valid <= (w_state_nxt == ST_VALID);
      r_fault       <= (w_state_nxt == ST_FAULT);
      r_fault_cause <= (w_state_nxt == ST_FAULT) ? w_cause_nxt : CAUSE_NONE;
      if (w_capture) begin
        r_instr_out <= i_imem_rdata;
        r_fetch_pc  <= i_pc;
      end
    end
  end

  assign o_pc_next_c   = w_pc_next;
  assign o_imem_addr_c = i_pc;
  assign o_imem_req    = r_imem_req;
  assign o_instr_valid = r_instr_valid;
  assign o_instr_out   = r_instr_out;
  assign o_fetch_pc    = r_fetch_pc;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_fault_cause;

endmodule
